riscv_run_ctrl: RTL

// - Run-mode sequencer for the single-cycle core: owns CPU reset, CPU clock-enable and UART-programmer reset.
// - Replaces the free-running divided CPU clock with a single-clock enable scheme.
// - Arbitrates the instruction/data memories between UART programming and CPU execution.
// - Adds halt and single-step debug modes. Sits between the board buttons/switches, uart_bmpg_0 and the core.

---
 rtl/riscv_run_ctrl_pkg.sv | 19 +
 rtl/riscv_debounce.sv | 54 +++++
 rtl/riscv_run_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_run_ctrl_pkg.sv
// Shared definitions for the run-mode sequencer: mode codes and FSM state encoding.
// The state encoding equals the mode code so the mode output is the state register itself.
package riscv_run_ctrl_pkg;

   localparam int unsigned RUN_MODE_LEN = 2;

   localparam logic [RUN_MODE_LEN-1:0] RUN_MODE_BOOT = 2'b00;
   localparam logic [RUN_MODE_LEN-1:0] RUN_MODE_RUN  = 2'b01;
   localparam logic [RUN_MODE_LEN-1:0] RUN_MODE_HALT = 2'b10;
   localparam logic [RUN_MODE_LEN-1:0] RUN_MODE_PROG = 2'b11;

   typedef enum logic [RUN_MODE_LEN-1:0] {
      StBoot = RUN_MODE_BOOT,
      StRun  = RUN_MODE_RUN,
      StHalt = RUN_MODE_HALT,
      StProg = RUN_MODE_PROG
   } run_state_e;

endpackage

// File: rtl/riscv_debounce.sv
// Button debouncer: a level must stay stable for DEBOUNCE_CYCLES samples before it is
// accepted; an accepted rising edge produces a one-cycle pulse. Input-to-pulse latency is
// DEBOUNCE_CYCLES+2 clock cycles (sync stage, counter, pulse register).
module riscv_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   output logic pulse_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            in_q;
   logic            stable_q, stable_d;
   logic            stable_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pulse_q;

   // Count consecutive samples that differ from the accepted level; any agreement restarts.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (in_q != stable_q) begin
         if (cnt_q == CntMax) begin
            stable_d = in_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Sync stage, debounce state and rising-edge pulse register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_q          <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
         pulse_q       <= 1'b0;
      end else begin
         in_q          <= in_i;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         cnt_q         <= cnt_d;
         pulse_q       <= stable_q & ~stable_prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run-mode sequencer for the single-cycle core: owns CPU reset, CPU clock-enable and the
// UART-programmer reset, arbitrates memories between programming and execution, and adds
// halt / single-step debug. Optional retired-instruction counter: RUN_CTRL_CYCLE_CNT_EN.
module riscv_run_ctrl
   import riscv_run_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV         = 1,
   parameter int unsigned BOOT_CYCLES     = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_pg,
   input  logic                    step_btn,
   input  logic                    run_sw,
   input  logic                    halt_req,
   input  logic                    upg_done,
   output logic                    cpu_en,
   output logic                    cpu_rst,
   output logic                    upg_rst,
   output logic [RUN_MODE_LEN-1:0] mode,
   output logic [31:0]             cycle_cnt
);

   localparam int unsigned DivW  = $clog2(CLK_DIV) + 1;
   localparam int unsigned BootW = $clog2(BOOT_CYCLES) + 1;
   localparam logic [DivW-1:0]  DivMax  = DivW'(CLK_DIV - 1);
   localparam logic [BootW-1:0] BootMax = BootW'(BOOT_CYCLES - 1);

   run_state_e       state_q, state_d;
   logic [DivW-1:0]  div_q, div_d;
   logic [BootW-1:0] boot_q, boot_d;
   logic             cpu_en_q, cpu_en_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             upg_rst_q, upg_rst_d;
   logic             seen_low_q, seen_low_d;
   logic             run_sw_q;
   logic             run_rise;
   logic             pg_p, step_p;

   riscv_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_pg_db (
      .clk    (clk),
      .rst    (rst),
      .in_i   (start_pg),
      .pulse_o(pg_p)
   );

   riscv_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_db (
      .clk    (clk),
      .rst    (rst),
      .in_i   (step_btn),
      .pulse_o(step_p)
   );

   assign run_rise = run_sw & ~run_sw_q;

   // Next state, divider/boot counters and registered output values.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      boot_d     = boot_q;
      cpu_en_d   = 1'b0;
      seen_low_d = seen_low_q;
      unique case (state_q)
         StBoot: begin
            if (pg_p) begin
               state_d = StProg;
               boot_d  = '0;
            end else if (boot_q == BootMax) begin
               state_d = run_sw ? StRun : StHalt;
               boot_d  = '0;
               div_d   = '0;
            end else begin
               boot_d = boot_q + BootW'(1);
            end
         end
         StRun: begin
            if (pg_p) begin
               state_d = StProg;
               div_d   = '0;
            end else if (cpu_en_q && halt_req) begin
               // The ebreak retires with this enable; no further enables follow.
               state_d = StHalt;
               div_d   = '0;
            end else if (!run_sw) begin
               state_d = StHalt;
               div_d   = '0;
            end else if (div_q == DivMax) begin
               div_d    = '0;
               cpu_en_d = 1'b1;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StHalt: begin
            if (pg_p) begin
               state_d = StProg;
            end else if (step_p) begin
               cpu_en_d = 1'b1;
            end else if (run_rise) begin
               state_d = StRun;
               div_d   = '0;
            end
         end
         StProg: begin
            // Only a done flag seen after a low period since entry completes programming.
            if (upg_done && seen_low_q) begin
               state_d = StBoot;
               boot_d  = '0;
            end else if (!upg_done) begin
               seen_low_d = 1'b1;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
      if (state_d == StProg && state_q != StProg) begin
         seen_low_d = 1'b0;
      end
      cpu_rst_d = (state_d == StBoot) || (state_d == StProg);
      upg_rst_d = (state_d != StProg);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StBoot;
         div_q      <= '0;
         boot_q     <= '0;
         cpu_en_q   <= 1'b0;
         cpu_rst_q  <= 1'b1;
         upg_rst_q  <= 1'b1;
         seen_low_q <= 1'b0;
         run_sw_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         boot_q     <= boot_d;
         cpu_en_q   <= cpu_en_d;
         cpu_rst_q  <= cpu_rst_d;
         upg_rst_q  <= upg_rst_d;
         seen_low_q <= seen_low_d;
         run_sw_q   <= run_sw;
      end
   end

   assign cpu_en  = cpu_en_q;
   assign cpu_rst = cpu_rst_q;
   assign upg_rst = upg_rst_q;
   assign mode    = state_q;

`ifdef RUN_CTRL_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;

   // Count retired instructions; a fresh boot restarts the count.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (state_d == StBoot && state_q != StBoot) begin
         cycle_cnt_d = '0;
      end else if (cpu_en_q) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
   end

   // Retired-instruction counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
`else
   assign cycle_cnt = 32'd0;
`endif

endmodule
